// File: rtl/vga_sched_pkg.sv
// Shared screen limits, field widths, FSM encoding and rectangle record for the draw scheduler.
package vga_sched_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned N_REQ    = 3;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned C_W      = 3;
    localparam int unsigned PX_W     = 9;
    localparam int unsigned PY_W     = 8;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSweep  = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
        logic [C_W-1:0] colour;
    } rect_t;

endpackage

// File: rtl/rect_sweeper.sv
// Raster walker over a latched rectangle: x/y offset counters, screen clipping and last-pixel flag.
module rect_sweeper
    import vga_sched_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [X_W-1:0] x0_i,
    input  logic [Y_W-1:0] y0_i,
    input  logic [X_W-1:0] w_i,
    input  logic [Y_W-1:0] h_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           visible_o,
    output logic           last_o
);

    logic [X_W-1:0]  cx_q, cx_d;
    logic [Y_W-1:0]  cy_q, cy_d;
    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
    logic            row_end;

    assign row_end = (cx_q == w_i - X_W'(1));

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (load_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (step_i) begin
            if (row_end) begin
                cx_d = '0;
                cy_d = cy_q + Y_W'(1);
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    // One extra bit so origin + offset never wraps back onto the screen.
    assign px        = {1'b0, x0_i} + {1'b0, cx_q};
    assign py        = {1'b0, y0_i} + {1'b0, cy_q};
    assign visible_o = (px < PX_W'(SCREEN_W)) && (py < PY_W'(SCREEN_H));
    assign x_o       = px[X_W-1:0];
    assign y_o       = py[Y_W-1:0];
    assign last_o    = row_end && (cy_q == h_i - Y_W'(1));

endmodule

// File: rtl/vga_draw_scheduler.sv
// Fixed-priority arbiter that latches one rectangle request and sweeps it into VGA pixel writes.
module vga_draw_scheduler
    import vga_sched_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    input  logic [N_REQ*X_W-1:0]   req_w,
    input  logic [N_REQ*Y_W-1:0]   req_h,
    input  logic [N_REQ*C_W-1:0]   req_colour,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   plot,
    output logic                   busy
);

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] owner_q, owner_d;
    rect_t            rect_q, rect_d;
    rect_t            sel_rect;
    logic [N_REQ-1:0] gnt_sel;
    logic             load;
    logic             sweeping;
    logic             visible;
    logic             last;
    logic [X_W-1:0]   sw_x;
    logic [Y_W-1:0]   sw_y;

    // Scan from the top index down so the lowest active requester wins.
    always_comb begin
        gnt_sel  = '0;
        sel_rect = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_sel         = '0;
                gnt_sel[i]      = 1'b1;
                sel_rect.x      = req_x[X_W*i +: X_W];
                sel_rect.y      = req_y[Y_W*i +: Y_W];
                sel_rect.w      = req_w[X_W*i +: X_W];
                sel_rect.h      = req_h[Y_W*i +: Y_W];
                sel_rect.colour = req_colour[C_W*i +: C_W];
            end
        end
    end

    assign gnt = (state_q == StIdle && !reset) ? gnt_sel : '0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rect_d  = rect_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (|gnt) begin
                    owner_d = gnt_sel;
                    rect_d  = sel_rect;
                    load    = 1'b1;
                    state_d = (sel_rect.w == '0 || sel_rect.h == '0) ? StFinish : StSweep;
                end
            end
            StSweep: begin
                if (last) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= '0;
            rect_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rect_q  <= rect_d;
        end
    end

    assign sweeping = (state_q == StSweep);

    rect_sweeper u_sweeper (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (load),
        .step_i    (sweeping),
        .x0_i      (rect_q.x),
        .y0_i      (rect_q.y),
        .w_i       (rect_q.w),
        .h_i       (rect_q.h),
        .x_o       (sw_x),
        .y_o       (sw_y),
        .visible_o (visible),
        .last_o    (last)
    );

    assign plot       = sweeping && visible;
    assign vga_x      = sweeping ? sw_x : '0;
    assign vga_y      = sweeping ? sw_y : '0;
    assign vga_colour = sweeping ? rect_q.colour : '0;
    assign done       = (state_q == StFinish) ? owner_q : '0;
    assign busy       = (state_q != StIdle);

endmodule

// File: doc/vga_draw_scheduler.md
VGA_DRAW_SCHEDULER -- requirements
Module: vga_draw_scheduler

Interface
REQ-001 SCREEN_W, 160, visible width in pixels; plotting limit on x.
REQ-002 SCREEN_H, 120, visible height in pixels; plotting limit on y.
REQ-003 Clocking and reset SHALL be one clock with a synchronous, active-high reset, on the ports below.
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  3  request per requester: bit0 erase, bit1 game draw, bit2 win/lose banner.
REQ-007 req_x  in  24  3x8-bit rectangle origin x, requester i at [8i+7:8i].
REQ-008 req_y  in  21  3x7-bit rectangle origin y, requester i at [7i+6:7i].
REQ-009 req_w  in  24  3x8-bit rectangle width in pixels.
REQ-010 req_h  in  21  3x7-bit rectangle height in pixels.
REQ-011 req_colour  in  9  3x3-bit fill colour.
REQ-012 gnt  out  3  one-hot, one-cycle pulse: request accepted and its fields latched.
REQ-013 done  out  3  one-hot, one-cycle pulse: the granted rectangle is complete.
REQ-014 vga_x  out  8  pixel x to the VGA adapter.
REQ-015 vga_y  out  7  pixel y to the VGA adapter.
REQ-016 vga_colour  out  3  pixel colour to the VGA adapter.
REQ-017 plot  out  1  write enable to the VGA adapter.
REQ-018 busy  out  1  high whenever the state is not IDLE.

Function
REQ-019 States SHALL be IDLE, SWEEP and FINISH.
REQ-020 In IDLE with any req bit high, the block SHALL grant the lowest-index active requester (fixed priority 0>1>2), pulse that gnt bit in the same cycle and latch its x, y, w, h and colour.
REQ-021 If the latched w or h is 0, the next state SHALL be FINISH; otherwise it SHALL be SWEEP.
REQ-022 SWEEP SHALL emit one pixel per cycle in raster order, x fastest: (x0,y0), (x0+1,y0) ... (x0+w-1,y0), (x0,y0+1) ... (x0+w-1,y0+h-1).
REQ-023 Pixel coordinates SHALL be computed at 9 bits for x and 8 bits for y.
REQ-024 A pixel with x>=SCREEN_W or y>=SCREEN_H SHALL hold plot=0 but still consume its cycle.
REQ-025 vga_x and vga_y SHALL carry the low bits of each coordinate; vga_colour SHALL equal the latched colour throughout SWEEP.
REQ-026 After the last pixel the state SHALL go to FINISH; FINISH SHALL last one cycle with done[granted]=1 and plot=0, then return to IDLE.
REQ-027 Latency: with a grant in cycle N, the first pixel SHALL appear in N+1, the last in N+w*h, and done in N+w*h+1 (N+1 when the area is 0).
REQ-028 A new grant SHALL NOT occur in FINISH; the earliest next grant is in the IDLE cycle that follows.
REQ-029 Requests arriving while busy SHALL be held pending, not lost; requesters keep req high until gnt.
REQ-030 req, req_* and colour changes after a grant SHALL NOT affect the active rectangle.
REQ-031 At most one gnt bit and one done bit SHALL be high in any cycle; plot SHALL be 0 outside SWEEP.

Reset
REQ-032 On reset the state SHALL be IDLE, and gnt, done, plot, busy, vga_x, vga_y and vga_colour SHALL all be 0.
REQ-033 Reset during SWEEP SHALL abort the rectangle with no done pulse; plot SHALL be 0 from the following cycle.

Structure
REQ-034 Package vga_sched_pkg SHALL hold SCREEN_W, SCREEN_H, N_REQ=3, the field widths and the state encoding.
REQ-035 Sub-module rect_sweeper SHALL implement the x/y counters, clipping and last-pixel flag; the top level holds arbitration, latching and the FSM.

Verification
REQ-036 req=001, x0=10, y0=20, w=3, h=2, colour=4 -> gnt=001; six plot cycles at (10,20)(11,20)(12,20)(10,21)(11,21)(12,21) with colour 4; done=001 one cycle after the last pixel.
REQ-037 req=111 held -> grant order erase, then draw, then banner; each grant occurs in the IDLE cycle after the previous done; no cycle has overlapping gnt or done bits.
REQ-038 x0=158, y0=119, w=4, h=2 -> eight SWEEP cycles; plot=1 only at (158,119) and (159,119); done at grant+9.
REQ-039 w=0, h=5 -> gnt, then done on the next cycle, with zero plot cycles.
REQ-040 reset asserted on the 3rd pixel of a 4x4 rectangle -> all outputs 0 on the next cycle, no done pulse; a fresh request afterwards completes normally.
REQ-041 req_x and req_colour changed mid-sweep -> pixels continue to use the values latched at grant.
